// File: rtl/obj_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obj_layer_pkg
// Purpose  : Shared defaults, object position type and state-bus field
//            offset helpers for the sprite-object layer.
// Revision : 1.0 - initial release
// ============================================================================
package obj_layer_pkg;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_SLOT_W  = 32;
  localparam int DEF_OBJ_W   = 40;
  localparam int DEF_OBJ_H   = 40;

  // One object position as exported by the game-state bus
  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
  } obj_pos_t;

  // LSB of object i's x field inside the packed state bus
  function automatic int x_lsb(input int i, input int slot_w = DEF_SLOT_W);
    return 2 * i * slot_w;
  endfunction

  // LSB of object i's y field inside the packed state bus
  function automatic int y_lsb(input int i, input int slot_w = DEF_SLOT_W);
    return (2 * i + 1) * slot_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obj_hit_test.sv
`default_nettype none
// ============================================================================
// Module   : obj_hit_test
// Purpose  : Stage-1 hit test for one object. Subtracts the object origin
//            from the pixel position and registers the in-sprite flag plus
//            the sprite-local offsets.
// Revision : 1.0 - initial release
// ============================================================================
module obj_hit_test
  import obj_layer_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int OBJ_W   = DEF_OBJ_W,
  parameter int OBJ_H   = DEF_OBJ_H
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic               blank_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               en,
  output logic               in_obj,
  output logic [COORD_W:0]   dx,
  output logic [COORD_W:0]   dy
);

  localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(OBJ_W);
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(OBJ_H);

  logic [COORD_W:0] dx_c;
  logic [COORD_W:0] dy_c;
  logic             in_c;

  // Subtraction form: a pixel left of / above the origin goes negative
  // (MSB set), so an origin near the screen edge cannot wrap into a hit.
  assign dx_c = {1'b0, draw_x} - {1'b0, x};
  assign dy_c = {1'b0, draw_y} - {1'b0, y};
  assign in_c = en & blank_n
              & ~dx_c[COORD_W] & (dx_c < W_LIM)
              & ~dy_c[COORD_W] & (dy_c < H_LIM);

  // Stage-1 pipeline registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      in_obj <= 1'b0;
      dx     <= '0;
      dy     <= '0;
    end else begin
      in_obj <= in_c;
      dx     <= dx_c;
      dy     <= dy_c;
    end
  end

endmodule
`default_nettype wire

// File: rtl/object_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : object_layer_engine
// Purpose  : Sprite-object layer. Snapshots object positions on each VS
//            falling edge, runs a 2-cycle per-pixel hit test with fixed
//            priority (lowest index wins), and reports per-frame overlaps.
// Revision : 1.0 - initial release
// ============================================================================
module object_layer_engine
  import obj_layer_pkg::*;
#(
  parameter int NUM_OBJ = 10,
  parameter int COORD_W = DEF_COORD_W,
  parameter int SLOT_W  = DEF_SLOT_W,
  parameter int OBJ_W   = DEF_OBJ_W,
  parameter int OBJ_H   = DEF_OBJ_H,
  parameter int ADDR_W  = 11
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [NUM_OBJ*2*SLOT_W-1:0] state_bus,
  input  logic [NUM_OBJ-1:0]          obj_en,
  input  logic                        VGA_VS,
  input  logic                        VGA_BLANK_N,
  input  logic [COORD_W-1:0]          DrawX,
  input  logic [COORD_W-1:0]          DrawY,
  output logic                        hit,
  output logic [$clog2(NUM_OBJ)-1:0]  obj_idx,
  output logic [ADDR_W-1:0]           spr_addr,
  output logic [NUM_OBJ-1:0]          coll_mask,
  output logic [15:0]                 frame_cnt
);

  localparam int              IDX_W    = $clog2(NUM_OBJ);
  localparam logic [ADDR_W-1:0] OBJ_W_A = ADDR_W'(OBJ_W);

  logic                vs_q;
  logic                snap;
  logic [NUM_OBJ-1:0]  shadow_en;
  logic [NUM_OBJ-1:0]  in_vec;
  logic [COORD_W:0]    dx_arr [NUM_OBJ];
  logic [COORD_W:0]    dy_arr [NUM_OBJ];
  logic [NUM_OBJ-1:0]  acc;
  logic                multi_hit;
  logic [IDX_W-1:0]    win_idx;
  logic [COORD_W:0]    win_dx;
  logic [COORD_W:0]    win_dy;
  logic [ADDR_W-1:0]   win_addr;
  logic                unused_bus_bits;

  // Only the low COORD_W bits of each slot carry a coordinate
  assign unused_bus_bits = ^state_bus;

  // VS history; reset high so a low VS at release still counts as a fall
  always_ff @(posedge Clk) begin
    if (!Reset_n) vs_q <= 1'b1;
    else          vs_q <= VGA_VS;
  end

  assign snap = vs_q & ~VGA_VS;

  // Per-object shadow registers and stage-1 hit test
  generate
    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
      localparam int XL = x_lsb(i, SLOT_W);
      localparam int YL = y_lsb(i, SLOT_W);

      logic [COORD_W-1:0] shadow_x;
      logic [COORD_W-1:0] shadow_y;

      // Load this object's position only at the frame edge to avoid tearing
      always_ff @(posedge Clk) begin
        if (!Reset_n) begin
          shadow_x     <= '0;
          shadow_y     <= '0;
          shadow_en[i] <= 1'b0;
        end else if (snap) begin
          shadow_x     <= state_bus[XL +: COORD_W];
          shadow_y     <= state_bus[YL +: COORD_W];
          shadow_en[i] <= obj_en[i];
        end
      end

      obj_hit_test #(
        .COORD_W (COORD_W),
        .OBJ_W   (OBJ_W),
        .OBJ_H   (OBJ_H)
      ) u_hit (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .draw_x  (DrawX),
        .draw_y  (DrawY),
        .blank_n (VGA_BLANK_N),
        .x       (shadow_x),
        .y       (shadow_y),
        .en      (shadow_en[i]),
        .in_obj  (in_vec[i]),
        .dx      (dx_arr[i]),
        .dy      (dy_arr[i])
      );
    end
  endgenerate

  // Fixed-priority encode: walk high to low so the lowest set index wins
  always_comb begin
    win_idx = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        win_idx = IDX_W'(i);
        win_dx  = dx_arr[i];
        win_dy  = dy_arr[i];
      end
    end
  end

  assign win_addr  = ADDR_W'(win_dy) * OBJ_W_A + ADDR_W'(win_dx);
  // Clearing the lowest set bit leaves something iff two or more were set
  assign multi_hit = |(in_vec & (in_vec - NUM_OBJ'(1)));

  // Stage-2 output registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hit      <= 1'b0;
      obj_idx  <= '0;
      spr_addr <= '0;
    end else begin
      hit      <= |in_vec;
      obj_idx  <= win_idx;
      spr_addr <= (|in_vec) ? win_addr : '0;
    end
  end

  // Collision accumulation and per-frame reporting
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      acc       <= '0;
      coll_mask <= '0;
      frame_cnt <= '0;
    end else if (snap) begin
      coll_mask <= acc;
      acc       <= '0;
      frame_cnt <= frame_cnt + 16'd1;
    end else if (multi_hit) begin
      acc <= acc | in_vec;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_object_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_object_layer_engine
// Purpose  : Self-checking bench: directed scenarios plus random traffic,
//            compared every cycle against a behavioural frame/pixel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_object_layer_engine;

  localparam int N  = 10;
  localparam int CW = 10;
  localparam int SW = 32;
  localparam int OW = 40;
  localparam int OH = 40;
  localparam int AW = 11;
  localparam int IW = $clog2(N);

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [N*2*SW-1:0] state_bus;
  logic [N-1:0]      obj_en;
  logic              VGA_VS;
  logic              VGA_BLANK_N;
  logic [CW-1:0]     DrawX;
  logic [CW-1:0]     DrawY;
  logic              hit;
  logic [IW-1:0]     obj_idx;
  logic [AW-1:0]     spr_addr;
  logic [N-1:0]      coll_mask;
  logic [15:0]       frame_cnt;

  object_layer_engine #(
    .NUM_OBJ (N), .COORD_W (CW), .SLOT_W (SW),
    .OBJ_W (OW), .OBJ_H (OH), .ADDR_W (AW)
  ) dut (
    .Clk (Clk), .Reset_n (Reset_n), .state_bus (state_bus), .obj_en (obj_en),
    .VGA_VS (VGA_VS), .VGA_BLANK_N (VGA_BLANK_N), .DrawX (DrawX), .DrawY (DrawY),
    .hit (hit), .obj_idx (obj_idx), .spr_addr (spr_addr),
    .coll_mask (coll_mask), .frame_cnt (frame_cnt)
  );

  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state: frame-latched positions and the result of the
  // pixel presented one clock ago (shown on the outputs one clock later).
  int       sx [N];
  int       sy [N];
  bit       sen [N];
  bit       vs_prev;
  bit [N-1:0] p_mask;
  int       p_idx, p_spr;
  bit       e_hit;
  int       e_idx, e_spr, e_fc;
  bit [N-1:0] e_coll, acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y);
    logic [SW-1:0] w;
    w = $urandom; w[CW-1:0] = CW'(x); state_bus[2*i*SW +: SW] = w;
    w = $urandom; w[CW-1:0] = CW'(y); state_bus[(2*i+1)*SW +: SW] = w;
  endtask

  task automatic model_edge();
    bit snap;
    bit [N-1:0] m;
    int ix, sp;
    if (!Reset_n) begin
      for (int i = 0; i < N; i++) begin sx[i] = 0; sy[i] = 0; sen[i] = 0; end
      p_mask = '0; p_idx = 0; p_spr = 0;
      e_hit = 0; e_idx = 0; e_spr = 0; e_coll = '0; acc = '0; e_fc = 0;
      vs_prev = 1'b1;
      return;
    end
    snap  = vs_prev && !VGA_VS;
    e_hit = (p_mask != '0);
    e_idx = p_idx;
    e_spr = p_spr;
    if (snap) begin
      e_coll = acc; acc = '0; e_fc = (e_fc + 1) % 65536;
    end else if ($countones(p_mask) >= 2) begin
      acc = acc | p_mask;
    end
    m = '0; ix = 0; sp = 0;
    for (int i = 0; i < N; i++) begin
      int dx, dy;
      dx = int'(DrawX) - sx[i];
      dy = int'(DrawY) - sy[i];
      if (sen[i] && VGA_BLANK_N && dx >= 0 && dx < OW && dy >= 0 && dy < OH) begin
        if (m == '0) begin ix = i; sp = dy * OW + dx; end
        m[i] = 1'b1;
      end
    end
    p_mask = m; p_idx = ix; p_spr = sp;
    if (snap) begin
      for (int i = 0; i < N; i++) begin
        sx[i]  = int'(state_bus[2*i*SW +: CW]);
        sy[i]  = int'(state_bus[(2*i+1)*SW +: CW]);
        sen[i] = obj_en[i];
      end
    end
    vs_prev = VGA_VS;
  endtask

  // One clock: advance the model on the edge, then compare every output
  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check("hit",       32'(hit),       32'(e_hit));
    check("obj_idx",   32'(obj_idx),   32'(e_idx));
    check("spr_addr",  32'(spr_addr),  32'(e_spr));
    check("coll_mask", 32'(coll_mask), 32'(e_coll));
    check("frame_cnt", 32'(frame_cnt), 32'(e_fc));
  endtask

  // Frame edge with the display blanked so no stray pixels straddle it
  task automatic vs_pulse();
    VGA_BLANK_N = 1'b0;
    VGA_VS = 1'b0; step();
    VGA_VS = 1'b1; step();
    VGA_BLANK_N = 1'b1;
  endtask

  // Present a pixel, wait the pipeline latency, then pin against literals
  task automatic probe(input string nm, input int x, input int y,
                       input bit h, input int idx, input int spr);
    DrawX = CW'(x); DrawY = CW'(y);
    step(); step();
    check({nm, "_hit"}, 32'(hit),      32'(h));
    check({nm, "_idx"}, 32'(obj_idx),  32'(idx));
    check({nm, "_spr"}, 32'(spr_addr), 32'(spr));
  endtask

  initial begin
    int vs_low;
    // Reset with arbitrary inputs
    Reset_n = 1'b0; VGA_VS = 1'b1; VGA_BLANK_N = 1'b1;
    state_bus = {N*2{$urandom}}; obj_en = '1;
    DrawX = 10'd5; DrawY = 10'd5;
    repeat (3) step();
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_frame", 32'(frame_cnt), 32'd0);
    Reset_n = 1'b1;
    repeat (6) begin
      DrawX = CW'($urandom); DrawY = CW'($urandom); step();
    end
    check("pre_snap_hit", 32'(hit), 32'd0);

    // Single object
    for (int i = 0; i < N; i++) set_obj(i, 900, 900);
    set_obj(0, 100, 50);
    obj_en = 10'b00_0000_0001;
    vs_pulse();
    check("frame_one", 32'(frame_cnt), 32'd1);
    probe("origin", 100, 50, 1'b1, 0, 0);
    probe("corner", 139, 89, 1'b1, 0, 1599);
    probe("right_out", 140, 50, 1'b0, 0, 0);
    probe("left_out", 99, 50, 1'b0, 0, 0);

    // Priority and collision
    set_obj(2, 200, 200); set_obj(5, 200, 200);
    obj_en = 10'b00_0010_0101;
    vs_pulse();
    probe("prio", 210, 210, 1'b1, 2, 410);
    set_obj(5, 400, 400);
    vs_pulse();
    check("coll_pair", 32'(coll_mask), 32'h024);
    probe("prio_alone", 210, 210, 1'b1, 2, 410);
    vs_pulse();
    check("coll_clear", 32'(coll_mask), 32'h000);

    // Anti-tearing
    set_obj(0, 300, 300);
    probe("old_pos", 100, 50, 1'b1, 0, 0);
    probe("new_pos_early", 300, 300, 1'b0, 0, 0);
    vs_pulse();
    probe("old_pos_late", 100, 50, 1'b0, 0, 0);
    probe("new_pos", 300, 300, 1'b1, 0, 0);

    // Right-edge wrap, blanking, enable
    set_obj(1, 630, 0);
    obj_en[1] = 1'b1;
    vs_pulse();
    probe("wrap", 5, 0, 1'b0, 0, 0);
    probe("edge_hit", 635, 0, 1'b1, 1, 5);
    VGA_BLANK_N = 1'b0;
    probe("blank", 635, 0, 1'b0, 0, 0);
    VGA_BLANK_N = 1'b1;
    obj_en[1] = 1'b0;
    vs_pulse();
    probe("disabled", 635, 0, 1'b0, 0, 0);

    // Reset mid-frame
    set_obj(0, 100, 50);
    vs_pulse();
    probe("pre_reset", 100, 50, 1'b1, 0, 0);
    Reset_n = 1'b0; step(); step();
    Reset_n = 1'b1; step();
    check("post_reset_hit", 32'(hit), 32'd0);
    probe("post_reset_miss", 100, 50, 1'b0, 0, 0);
    vs_pulse();
    check("post_reset_frame", 32'(frame_cnt), 32'd1);
    probe("post_reset_hit2", 100, 50, 1'b1, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < N; i++) set_obj(i, $urandom_range(0, 220), $urandom_range(0, 220));
    obj_en = N'($urandom);
    vs_low = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        DrawX = CW'($urandom); DrawY = CW'($urandom);
      end else begin
        DrawX = CW'($urandom_range(0, 280)); DrawY = CW'($urandom_range(0, 280));
      end
      VGA_BLANK_N = ($urandom_range(0, 4) != 0);
      if (vs_low > 0) begin
        VGA_VS = 1'b0; vs_low--;
      end else begin
        VGA_VS = 1'b1;
        if ($urandom_range(0, 149) == 0) vs_low = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 4) == 0)
          set_obj($urandom_range(0, N-1), $urandom_range(990, 1023), $urandom_range(990, 1023));
        else
          set_obj($urandom_range(0, N-1), $urandom_range(0, 220), $urandom_range(0, 220));
      end
      if ($urandom_range(0, 99) == 0) obj_en = N'($urandom);
      Reset_n = ($urandom_range(0, 999) != 0);
      step();
    end
    Reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
